id_hazard_controller: RTL and testbench

//  Sequences the ID-stage destination-register path. Decodes the opcode into RegDst, RegWrite and MemRead.

---
 rtl/id_hazard_if.sv | 37 +++
 rtl/id_hazard_controller.sv | 133 +++++++++++++
 tb/tb_id_hazard_controller.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/id_hazard_if.sv
// ID-stage hazard controller bus: the decode-stage instruction fields in,
// pipeline control, forwarding selects and regfile write port out.
interface id_hazard_if #(
  parameter int REG_ADDR_W = 5,
  parameter int OPCODE_W   = 6,
  parameter int CNT_W      = 16
);
  logic                  i_valid;
  logic                  i_flush;
  logic [OPCODE_W-1:0]   i_opcode;
  logic [REG_ADDR_W-1:0] i_rs;
  logic [REG_ADDR_W-1:0] i_rt;
  logic [REG_ADDR_W-1:0] i_rd;
  logic                  o_reg_dst_sel;
  logic                  o_pc_we;
  logic                  o_ifid_we;
  logic                  o_idex_bubble;
  logic [1:0]            o_fwd_a;
  logic [1:0]            o_fwd_b;
  logic [REG_ADDR_W-1:0] o_wb_dest;
  logic                  o_wb_we;
  logic [CNT_W-1:0]      o_stall_cnt;

  // Pipeline side: presents the ID instruction, consumes the control outputs.
  modport master (
    output i_valid, i_flush, i_opcode, i_rs, i_rt, i_rd,
    input  o_reg_dst_sel, o_pc_we, o_ifid_we, o_idex_bubble,
           o_fwd_a, o_fwd_b, o_wb_dest, o_wb_we, o_stall_cnt
  );

  // Controller side.
  modport slave (
    input  i_valid, i_flush, i_opcode, i_rs, i_rt, i_rd,
    output o_reg_dst_sel, o_pc_we, o_ifid_we, o_idex_bubble,
           o_fwd_a, o_fwd_b, o_wb_dest, o_wb_we, o_stall_cnt
  );
endinterface

// File: rtl/id_hazard_controller.sv
// ID-stage destination-register sequencer: opcode decode, a shadow
// EX/MEM/WB pipeline of register usage, load-use stall generation,
// EX-stage forwarding selects and the regfile write port.
module id_hazard_controller #(
  parameter int REG_ADDR_W = 5,
  parameter int OPCODE_W   = 6,
  parameter int CNT_W      = 16
) (
  input  logic        i_clk,
  input  logic        reset,
  id_hazard_if.slave  bus
);

  localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'('h00);
  localparam logic [OPCODE_W-1:0] OP_J     = OPCODE_W'('h02);
  localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'('h04);
  localparam logic [OPCODE_W-1:0] OP_BNE   = OPCODE_W'('h05);
  localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'('h08);
  localparam logic [OPCODE_W-1:0] OP_SLTI  = OPCODE_W'('h0A);
  localparam logic [OPCODE_W-1:0] OP_ANDI  = OPCODE_W'('h0C);
  localparam logic [OPCODE_W-1:0] OP_ORI   = OPCODE_W'('h0D);
  localparam logic [OPCODE_W-1:0] OP_LUI   = OPCODE_W'('h0F);
  localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'('h23);
  localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'('h2B);

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  typedef struct packed {
    logic                  valid;
    logic                  we;
    logic                  memread;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic [REG_ADDR_W-1:0] dest;
  } stage_t;

  stage_t ex_q, mem_q, wb_q;
  stage_t id_entry;

  logic                  dec_sel_rt;
  logic                  dec_we;
  logic                  dec_memread;
  logic                  uses_rs;
  logic                  uses_rt;
  logic [REG_ADDR_W-1:0] dec_dest;
  logic                  stall;
  logic                  bubble;
  logic [CNT_W-1:0]      stall_cnt_q;

  // Opcode decode: destination select, write/load flags and source usage.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    dec_sel_rt  = 1'b0;
    dec_we      = 1'b0;
    dec_memread = 1'b0;
    uses_rs     = 1'b1;
    uses_rt     = 1'b0;
    case (bus.i_opcode)
      OP_RTYPE: begin dec_we = 1'b1; uses_rt = 1'b1; end
      OP_LW:    begin dec_sel_rt = 1'b1; dec_we = 1'b1; dec_memread = 1'b1; end
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI:
                begin dec_sel_rt = 1'b1; dec_we = 1'b1; end
      OP_LUI:   begin dec_sel_rt = 1'b1; dec_we = 1'b1; uses_rs = 1'b0; end
      OP_SW, OP_BEQ, OP_BNE:
                uses_rt = 1'b1;
      OP_J:     uses_rs = 1'b0;
      default:  ;
    endcase
  end

  assign dec_dest = dec_sel_rt ? bus.i_rt : bus.i_rd;

  // Decoded ID entry; writes to register 0 are dropped at the source.
  assign id_entry = '{valid:   1'b1,
                      we:      dec_we && (dec_dest != '0),
                      memread: dec_memread,
                      rs:      bus.i_rs,
                      rt:      bus.i_rt,
                      dest:    dec_dest};

  // Load-use hazard: a load in EX feeding a source the ID instruction reads.
  // A flush kills the ID instruction, so it can never stall.
  assign stall = bus.i_valid && !bus.i_flush && ex_q.valid && ex_q.memread &&
                 (ex_q.dest != '0) &&
                 ((uses_rs && (bus.i_rs == ex_q.dest)) ||
                  (uses_rt && (bus.i_rt == ex_q.dest)));

  assign bubble = stall || bus.i_flush || !bus.i_valid;

  // Forwarding select for one EX source; MEM wins over WB.
  function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] src,
                                         input stage_t mem, input stage_t wb);
    if (src == '0)                                fwd_sel = FWD_RF;
    else if (mem.valid && mem.we && mem.dest == src) fwd_sel = FWD_MEM;
    else if (wb.valid && wb.we && wb.dest == src)    fwd_sel = FWD_WB;
    else                                          fwd_sel = FWD_RF;
  endfunction

  // Shadow pipeline advance and saturating stall counter.
  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments let WB<=MEM<=EX shift in one edge using pre-edge values.
      wb_q  <= mem_q;
      mem_q <= ex_q;
      ex_q  <= bubble ? stage_t'('0) : id_entry;
      if (stall && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign bus.o_reg_dst_sel = dec_sel_rt;
  assign bus.o_pc_we       = !stall;
  assign bus.o_ifid_we     = !stall;
  assign bus.o_idex_bubble = bubble;
  assign bus.o_fwd_a       = fwd_sel(ex_q.rs, mem_q, wb_q);
  assign bus.o_fwd_b       = fwd_sel(ex_q.rt, mem_q, wb_q);
  assign bus.o_wb_dest     = wb_q.dest;
  assign bus.o_wb_we       = wb_q.valid && wb_q.we;
  assign bus.o_stall_cnt   = stall_cnt_q;

  // Later-stage source fields and load flags are carried for debug visibility only.
  logic unused_stage_bits;
  assign unused_stage_bits = ^{mem_q.memread, mem_q.rs, mem_q.rt,
                               wb_q.memread, wb_q.rs, wb_q.rt};

endmodule

// File: tb/tb_id_hazard_controller.sv
// Directed bench for id_hazard_controller: a vector table walks the decode,
// hazard, forwarding and write-port paths cycle by cycle; hand sequences
// cover reset during a stall and counter saturation (on a 4-bit instance).
module tb_id_hazard_controller;

  localparam logic [5:0] R    = 6'h00;
  localparam logic [5:0] J    = 6'h02;
  localparam logic [5:0] ADDI = 6'h08;
  localparam logic [5:0] LUI  = 6'h0F;
  localparam logic [5:0] LW   = 6'h23;
  localparam logic [5:0] SW   = 6'h2B;

  logic i_clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 i_clk = ~i_clk;

  id_hazard_if #(.REG_ADDR_W(5), .OPCODE_W(6), .CNT_W(16)) hif ();
  id_hazard_if #(.REG_ADDR_W(5), .OPCODE_W(6), .CNT_W(4))  sif ();

  id_hazard_controller #(.REG_ADDR_W(5), .OPCODE_W(6), .CNT_W(16)) dut (
    .i_clk (i_clk),
    .reset (reset),
    .bus   (hif)
  );

  id_hazard_controller #(.REG_ADDR_W(5), .OPCODE_W(6), .CNT_W(4)) dut_sat (
    .i_clk (i_clk),
    .reset (reset),
    .bus   (sif)
  );

  typedef struct {
    logic       valid;
    logic       flush;
    logic [5:0] op;
    logic [4:0] rs, rt, rd;
    logic       e_sel;
    logic       e_pc_we;
    logic       e_bubble;
    logic [1:0] e_fwd_a, e_fwd_b;
    logic       e_wb_we;
    logic [4:0] e_wb_dest;
    logic [15:0] e_cnt;
  } vec_t;

  localparam int NVEC = 24;
  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic v, f, input logic [5:0] op,
                              input logic [4:0] rs, rt, rd,
                              input logic sel, pc, bub, input logic [1:0] fa, fb,
                              input logic wbwe, input logic [4:0] wbd,
                              input logic [15:0] cnt);
    vec_t t;
    t.valid = v; t.flush = f; t.op = op; t.rs = rs; t.rt = rt; t.rd = rd;
    t.e_sel = sel; t.e_pc_we = pc; t.e_bubble = bub; t.e_fwd_a = fa; t.e_fwd_b = fb;
    t.e_wb_we = wbwe; t.e_wb_dest = wbd; t.e_cnt = cnt;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, f, input logic [5:0] op, input logic [4:0] rs, rt, rd);
    hif.i_valid = v; hif.i_flush = f; hif.i_opcode = op;
    hif.i_rs = rs; hif.i_rt = rt; hif.i_rd = rd;
  endtask

  // Advance one clock and land just after the edge.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    // Instruction stream: one entry per cycle; stalled instructions are re-presented.
    //               v f op   rs rt rd  sel pc bub fa fb wbwe wbd cnt
    vecs[0]  = mk(1,0,LW,   1, 8, 0,  1, 1, 0, 0, 0, 0, 0, 0); // lw $8,0($1)
    vecs[1]  = mk(1,0,R,    8,10, 9,  0, 0, 1, 0, 0, 0, 0, 0); // add $9,$8,$10: stall
    vecs[2]  = mk(1,0,R,    8,10, 9,  0, 1, 0, 0, 0, 0, 0, 1); // released
    vecs[3]  = mk(0,0,R,    0, 0, 0,  0, 1, 1, 1, 0, 1, 8, 1); // add in EX, fwd_a from WB
    vecs[4]  = mk(1,0,R,    1, 2, 3,  0, 1, 0, 0, 0, 0, 0, 1); // add $3,$1,$2
    vecs[5]  = mk(1,0,R,    3, 3, 4,  0, 1, 0, 0, 0, 1, 9, 1); // sub $4,$3,$3
    vecs[6]  = mk(0,0,R,    0, 0, 0,  0, 1, 1, 2, 2, 0, 0, 1); // sub in EX: both from MEM
    vecs[7]  = mk(1,0,ADDI, 1, 0, 0,  1, 1, 0, 0, 0, 1, 3, 1); // addi $0,$1,5
    vecs[8]  = mk(1,0,R,    0, 0, 5,  0, 1, 0, 0, 0, 1, 4, 1); // add $5,$0,$0
    vecs[9]  = mk(0,0,R,    0, 0, 0,  0, 1, 1, 0, 0, 0, 0, 1);
    vecs[10] = mk(0,0,R,    0, 0, 0,  0, 1, 1, 0, 0, 0, 0, 1); // addi in WB: no write
    vecs[11] = mk(0,0,R,    0, 0, 0,  0, 1, 1, 0, 0, 1, 5, 1);
    vecs[12] = mk(1,0,LW,   1, 8, 0,  1, 1, 0, 0, 0, 0, 0, 1); // lw $8,0($1)
    vecs[13] = mk(1,1,R,    8,10, 9,  0, 1, 1, 0, 0, 0, 0, 1); // flushed use: no stall
    vecs[14] = mk(0,0,R,    0, 0, 0,  0, 1, 1, 0, 0, 0, 0, 1); // counter unchanged
    vecs[15] = mk(1,0,LW,   2, 7, 0,  1, 1, 0, 0, 0, 1, 8, 1); // lw $7,0($2)
    vecs[16] = mk(1,0,LUI,  7, 9, 0,  1, 1, 0, 0, 0, 0, 0, 1); // lui ignores rs: no stall
    vecs[17] = mk(1,0,SW,   3, 7, 0,  0, 1, 0, 2, 0, 0, 0, 1); // sw $7,0($3)
    vecs[18] = mk(1,0,LW,   3, 6, 0,  1, 1, 0, 0, 1, 1, 7, 1); // lw $6,0($3)
    vecs[19] = mk(1,0,SW,   4, 6, 0,  0, 0, 1, 0, 0, 1, 9, 1); // sw $6: stall via rt
    vecs[20] = mk(1,0,SW,   4, 6, 0,  0, 1, 0, 0, 0, 0, 0, 2);
    vecs[21] = mk(0,0,R,    0, 0, 0,  0, 1, 1, 0, 1, 1, 6, 2); // sw in EX, fwd_b from WB
    vecs[22] = mk(1,0,LW,   1, 5, 0,  1, 1, 0, 0, 0, 0, 0, 2); // lw $5,0($1)
    vecs[23] = mk(1,0,J,    5, 5, 0,  0, 1, 0, 0, 0, 0, 0, 2); // j reads nothing: no stall

    drive(0, 0, R, 0, 0, 0);
    sif.i_valid = 1'b0; sif.i_flush = 1'b0; sif.i_opcode = R;
    sif.i_rs = '0; sif.i_rt = '0; sif.i_rd = '0;

    // Reset state.
    #3;
    check("rst pc_we",     hif.o_pc_we, 1);
    check("rst ifid_we",   hif.o_ifid_we, 1);
    check("rst bubble",    hif.o_idex_bubble, 1);
    check("rst fwd_a",     hif.o_fwd_a, 0);
    check("rst fwd_b",     hif.o_fwd_b, 0);
    check("rst wb_we",     hif.o_wb_we, 0);
    check("rst wb_dest",   hif.o_wb_dest, 0);
    check("rst stall_cnt", hif.o_stall_cnt, 0);
    #9 reset = 1'b0;
    tick();

    // Table-driven walk.
    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].valid, vecs[i].flush, vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].rd);
      #2;
      check($sformatf("v%0d reg_dst_sel", i), hif.o_reg_dst_sel, vecs[i].e_sel);
      check($sformatf("v%0d pc_we", i),       hif.o_pc_we, vecs[i].e_pc_we);
      check($sformatf("v%0d ifid_we", i),     hif.o_ifid_we, vecs[i].e_pc_we);
      check($sformatf("v%0d bubble", i),      hif.o_idex_bubble, vecs[i].e_bubble);
      check($sformatf("v%0d fwd_a", i),       hif.o_fwd_a, vecs[i].e_fwd_a);
      check($sformatf("v%0d fwd_b", i),       hif.o_fwd_b, vecs[i].e_fwd_b);
      check($sformatf("v%0d wb_we", i),       hif.o_wb_we, vecs[i].e_wb_we);
      if (vecs[i].e_wb_we)
        check($sformatf("v%0d wb_dest", i),   hif.o_wb_dest, vecs[i].e_wb_dest);
      check($sformatf("v%0d stall_cnt", i),   hif.o_stall_cnt, vecs[i].e_cnt);
      tick();
    end

    // Reset asserted during a load-use stall cycle.
    drive(1, 0, LW, 1, 8, 0);
    tick();
    drive(1, 0, R, 8, 10, 9);
    #2;
    check("rs5 stall before reset", hif.o_pc_we, 0);
    check("rs5 cnt before reset",   hif.o_stall_cnt, 2);
    reset = 1'b1;
    #1;
    check("rs5 pc_we in reset",   hif.o_pc_we, 1);
    check("rs5 ifid_we in reset", hif.o_ifid_we, 1);
    check("rs5 bubble in reset",  hif.o_idex_bubble, 0);
    check("rs5 cnt in reset",     hif.o_stall_cnt, 0);
    check("rs5 fwd_a in reset",   hif.o_fwd_a, 0);
    check("rs5 fwd_b in reset",   hif.o_fwd_b, 0);
    check("rs5 wb_we in reset",   hif.o_wb_we, 0);
    check("rs5 wb_dest in reset", hif.o_wb_dest, 0);
    #1 reset = 1'b0;
    #1;
    check("rs5 add no stall", hif.o_pc_we, 1);
    check("rs5 add bubble",   hif.o_idex_bubble, 0);
    tick();
    drive(0, 0, R, 0, 0, 0);
    tick();
    tick();
    #1;
    check("rs5 add wb_we",   hif.o_wb_we, 1);
    check("rs5 add wb_dest", hif.o_wb_dest, 9);
    check("rs5 cnt after",   hif.o_stall_cnt, 0);

    // Saturation on the 4-bit instance: lw $8,0($8) back to back stalls every other cycle.
    sif.i_valid = 1'b1; sif.i_opcode = LW; sif.i_rs = 5'd8; sif.i_rt = 5'd8; sif.i_rd = 5'd0;
    #1;
    check("sat first lw no stall", sif.o_pc_we, 1);
    for (int c = 0; c < 28; c++) tick();
    #1;
    check("sat preload 0xE", sif.o_stall_cnt, 4'hE);
    tick();
    #1;
    check("sat stall cycle pc_we", sif.o_pc_we, 0);
    tick();
    #1;
    check("sat reaches 0xF", sif.o_stall_cnt, 4'hF);
    tick();
    #1;
    check("sat stall at max", sif.o_pc_we, 0);
    tick();
    #1;
    check("sat holds 0xF", sif.o_stall_cnt, 4'hF);
    sif.i_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
